// File: rtl/pipe_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   pc_src_t      : encoding of the pc_source redirect selector
//   fetch_state_t : fetch controller states
package pipe_pkg;

   typedef enum logic [1:0] {
      PC_SRC_SEQ    = 2'd0,
      PC_SRC_BRANCH = 2'd1,
      PC_SRC_REG    = 2'd2,
      PC_SRC_JUMP   = 2'd3
   } pc_src_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,  // no request outstanding
      REQ  = 2'd1,  // request outstanding, response will be kept
      DROP = 2'd2   // request outstanding, response will be discarded
   } fetch_state_t;

endpackage

// File: rtl/pipe_fetch_if.sv
// Bus bundle between the fetch stage, instruction memory and decode.
//   imem_req/imem_addr   : fetch request and address (fetch -> memory)
//   imem_ack/imem_rdata  : completion and instruction (memory -> fetch)
//   if_valid/if_pc/if_pc_plus_4/if_inst : buffer head (fetch -> decode)
//   id_ready             : decode accepts the head (decode -> fetch)
// master = fetch-stage view, slave = memory/decode view.
interface pipe_fetch_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [INST_W-1:0] imem_rdata;
   logic              if_valid;
   logic [ADDR_W-1:0] if_pc;
   logic [ADDR_W-1:0] if_pc_plus_4;
   logic [INST_W-1:0] if_inst;
   logic              id_ready;

   modport master (
      output imem_req, imem_addr, if_valid, if_pc, if_pc_plus_4, if_inst,
      input  imem_ack, imem_rdata, id_ready
   );

   modport slave (
      input  imem_req, imem_addr, if_valid, if_pc, if_pc_plus_4, if_inst,
      output imem_ack, imem_rdata, id_ready
   );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push, din    : write an entry (accepted when not full, or full with pop)
//   pop          : remove the head (ignored when empty)
//   flush        : empty the FIFO, overrides push and pop
//   dout, count  : head entry and current occupancy
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      do_pop  = pop && (count_q != '0);
      // a full FIFO still takes a push when the head leaves in the same cycle
      do_push = push && ((count_q != DEPTH_C) || do_pop);
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign count = count_q;
endmodule

// File: rtl/pipe_fetch.sv
// Instruction-fetch stage: registered PC, single-outstanding request/ack
// memory port, redirect handling and a fetch buffer feeding decode.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   pc_source      : 0 sequential, 1 branch_pc, 2 register_pc, 3 jump_pc
//   branch_pc, register_pc, jump_pc : redirect targets (low 2 bits dropped)
//   bus            : memory request/response and decode-side head signals
module pipe_fetch
   import pipe_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter int                INST_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter int                FIFO_DEPTH = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [1:0]        pc_source,
   input  logic [ADDR_W-1:0] branch_pc,
   input  logic [ADDR_W-1:0] register_pc,
   input  logic [ADDR_W-1:0] jump_pc,
   pipe_fetch_if.master      bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   fetch_state_t             state, state_nx;
   logic [ADDR_W-1:0]        pc, pc_nx, pc_inc;
   logic [ADDR_W-1:0]        req_addr, req_addr_nx;
   logic [ADDR_W-1:0]        sel, target;
   logic                     redirect, push, pop, valid;
   logic [CW-1:0]            count, count_after;
   logic [ADDR_W+INST_W-1:0] head;

   always_comb begin
      unique case (pc_src_t'(pc_source))
         PC_SRC_BRANCH: sel = branch_pc;
         PC_SRC_REG:    sel = register_pc;
         PC_SRC_JUMP:   sel = jump_pc;
         default:       sel = pc;
      endcase
      target   = {sel[ADDR_W-1:2], 2'b00};
      redirect = (pc_src_t'(pc_source) != PC_SRC_SEQ);
   end

   assign valid       = (count != '0);
   assign pop         = valid && bus.id_ready;
   assign push        = (state == REQ) && bus.imem_ack && !redirect;
   assign pc_inc      = pc + ADDR_W'(4);
   assign count_after = count + CW'(push) - CW'(pop);

   always_comb begin
      state_nx    = state;
      pc_nx       = pc;
      req_addr_nx = req_addr;
      if (push) pc_nx = pc_inc;
      unique case (state)
         IDLE: begin
            if (redirect) begin
               state_nx    = REQ;
               req_addr_nx = target;
            end else if (count < DEPTH_C) begin
               state_nx    = REQ;
               req_addr_nx = pc;
            end
         end
         REQ: begin
            if (redirect) begin
               // a response landing with the redirect is simply not pushed
               if (bus.imem_ack) req_addr_nx = target;
               else              state_nx    = DROP;
            end else if (bus.imem_ack) begin
               if (count_after < DEPTH_C) req_addr_nx = pc_inc;
               else                       state_nx    = IDLE;
            end
         end
         DROP: begin
            if (bus.imem_ack) begin
               state_nx    = REQ;
               req_addr_nx = redirect ? target : pc;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (redirect) pc_nx = target;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         req_addr <= RESET_PC;
      end else begin
         state    <= state_nx;
         pc       <= pc_nx;
         req_addr <= req_addr_nx;
      end
   end

   fetch_fifo #(
      .WIDTH(ADDR_W + INST_W),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clock(clock),
      .reset(reset),
      .push (push),
      .pop  (pop),
      .flush(redirect),
      .din  ({req_addr, bus.imem_rdata}),
      .dout (head),
      .count(count)
   );

   assign bus.imem_req     = (state != IDLE);
   assign bus.imem_addr    = req_addr;
   assign bus.if_valid     = valid;
   assign bus.if_pc        = valid ? head[ADDR_W+INST_W-1:INST_W] : '0;
   assign bus.if_inst      = valid ? head[INST_W-1:0] : '0;
   assign bus.if_pc_plus_4 = valid ? bus.if_pc + ADDR_W'(4) : '0;
endmodule

// File: tb/tb_pipe_fetch.sv
// Directed bench for pipe_fetch: reset state, streaming, decode stall,
// redirects (DROP path, ack-coincident, repeated), address wrap and
// reset during an outstanding request. Memory returns addr ^ K.
module tb_pipe_fetch;
   localparam logic [31:0] K = 32'hA5A5_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  pc_source;
   logic [31:0] branch_pc, register_pc, jump_pc;
   int unsigned vectors = 0;
   int unsigned errors  = 0;

   pipe_fetch_if #(.ADDR_W(32), .INST_W(32)) bus ();

   pipe_fetch #(
      .ADDR_W(32),
      .INST_W(32),
      .RESET_PC(32'h0),
      .FIFO_DEPTH(2)
   ) dut (
      .clock(clock),
      .reset(reset),
      .pc_source(pc_source),
      .branch_pc(branch_pc),
      .register_pc(register_pc),
      .jump_pc(jump_pc),
      .bus(bus)
   );

   assign bus.imem_rdata = bus.imem_addr ^ K;

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1; pc_source = 2'd0; bus.imem_ack = 1'b0; bus.id_ready = 1'b0;
      branch_pc = '0; register_pc = '0; jump_pc = '0;
      step(); step();
   endtask

   task automatic test_reset();
      apply_reset();
      vectors++;
      if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0) begin
         errors++; $display("FAIL reset_req: req=%0b addr=%h exp req=0 addr=0", bus.imem_req, bus.imem_addr);
      end
      vectors++;
      if (bus.if_valid !== 1'b0 || bus.if_pc !== 32'h0 || bus.if_pc_plus_4 !== 32'h0 || bus.if_inst !== 32'h0) begin
         errors++; $display("FAIL reset_head: valid=%0b pc=%h p4=%h inst=%h exp all 0",
                            bus.if_valid, bus.if_pc, bus.if_pc_plus_4, bus.if_inst);
      end
      reset = 1'b0;
   endtask

   task automatic test_stream();
      apply_reset(); reset = 1'b0;
      bus.imem_ack = 1'b1; bus.id_ready = 1'b1;
      step();
      vectors++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.if_valid !== 1'b0) begin
         errors++; $display("FAIL stream_first_req: req=%0b addr=%h valid=%0b exp 1/0/0",
                            bus.imem_req, bus.imem_addr, bus.if_valid);
      end
      for (int i = 0; i < 6; i++) begin
         logic [31:0] e;
         e = 32'(i) * 32'd4;
         step();
         vectors++;
         if (bus.if_valid !== 1'b1 || bus.if_pc !== e || bus.if_pc_plus_4 !== e + 32'd4 ||
             bus.if_inst !== (e ^ K) || bus.imem_addr !== e + 32'd4) begin
            errors++; $display("FAIL stream_%0d: valid=%0b pc=%h p4=%h inst=%h addr=%h exp pc=%h",
                               i, bus.if_valid, bus.if_pc, bus.if_pc_plus_4, bus.if_inst, bus.imem_addr, e);
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] exp_pc;
      int unsigned got;
      apply_reset(); reset = 1'b0;
      bus.imem_ack = 1'b1; bus.id_ready = 1'b1;
      for (int i = 0; i < 7; i++) step();   // head now 0x14, request at 0x18
      bus.id_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         vectors++;
         if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b1 || bus.if_pc !== 32'h14) begin
            errors++; $display("FAIL stall_%0d: req=%0b valid=%0b pc=%h exp req=0 valid=1 pc=00000014",
                               i, bus.imem_req, bus.if_valid, bus.if_pc);
         end
      end
      bus.id_ready = 1'b1;
      exp_pc = 32'h14;
      got = 0;
      for (int c = 0; c < 30 && got < 6; c++) begin
         if (bus.if_valid === 1'b1) begin
            vectors++;
            if (bus.if_pc !== exp_pc) begin
               errors++; $display("FAIL stall_release_%0d: pc=%h exp %h", got, bus.if_pc, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
            got++;
         end
         step();
      end
      if (got < 6) begin
         vectors++; errors++;
         $display("FAIL stall_release_timeout: delivered %0d exp 6", got);
      end
   endtask

   task automatic test_jump_drop();
      apply_reset(); reset = 1'b0;
      bus.imem_ack = 1'b0; bus.id_ready = 1'b1;
      step();                                  // REQ at 0
      pc_source = 2'd3; jump_pc = 32'h100;
      step();                                  // now DROP
      pc_source = 2'd0;
      vectors++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.if_valid !== 1'b0) begin
         errors++; $display("FAIL jump_drop_hold: req=%0b addr=%h valid=%0b exp 1/0/0",
                            bus.imem_req, bus.imem_addr, bus.if_valid);
      end
      step();
      bus.imem_ack = 1'b1;
      step();
      vectors++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || bus.if_valid !== 1'b0) begin
         errors++; $display("FAIL jump_target_req: req=%0b addr=%h valid=%0b exp 1/00000100/0",
                            bus.imem_req, bus.imem_addr, bus.if_valid);
      end
      step();
      vectors++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100 || bus.if_inst !== (32'h100 ^ K) ||
          bus.if_pc_plus_4 !== 32'h104) begin
         errors++; $display("FAIL jump_first_pc: valid=%0b pc=%h inst=%h p4=%h exp pc=00000100",
                            bus.if_valid, bus.if_pc, bus.if_inst, bus.if_pc_plus_4);
      end
   endtask

   task automatic test_branch_on_ack();
      apply_reset(); reset = 1'b0;
      bus.imem_ack = 1'b1; bus.id_ready = 1'b0;
      step(); step();                          // one entry buffered, REQ at 4
      vectors++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.imem_addr !== 32'h4) begin
         errors++; $display("FAIL branch_setup: valid=%0b pc=%h addr=%h exp 1/0/00000004",
                            bus.if_valid, bus.if_pc, bus.imem_addr);
      end
      pc_source = 2'd1; branch_pc = 32'h43;
      step();
      pc_source = 2'd0;
      vectors++;
      if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
         errors++; $display("FAIL branch_flush: valid=%0b req=%0b addr=%h exp 0/1/00000040",
                            bus.if_valid, bus.imem_req, bus.imem_addr);
      end
      bus.id_ready = 1'b1;
      step();
      vectors++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h40 || bus.if_inst !== (32'h40 ^ K)) begin
         errors++; $display("FAIL branch_first_pc: valid=%0b pc=%h inst=%h exp pc=00000040",
                            bus.if_valid, bus.if_pc, bus.if_inst);
      end
   endtask

   task automatic test_double_redirect();
      apply_reset(); reset = 1'b0;
      bus.imem_ack = 1'b0; bus.id_ready = 1'b1;
      step();
      pc_source = 2'd1; branch_pc = 32'h80;
      step();                                  // DROP
      pc_source = 2'd3; jump_pc = 32'h200;
      step();                                  // still DROP, later target wins
      pc_source = 2'd0;
      vectors++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
         errors++; $display("FAIL dbl_drop_hold: req=%0b addr=%h exp 1/0", bus.imem_req, bus.imem_addr);
      end
      bus.imem_ack = 1'b1;
      step();
      vectors++;
      if (bus.imem_addr !== 32'h200 || bus.if_valid !== 1'b0) begin
         errors++; $display("FAIL dbl_target: addr=%h valid=%0b exp 00000200/0", bus.imem_addr, bus.if_valid);
      end
   endtask

   task automatic test_wrap();
      apply_reset(); reset = 1'b0;
      bus.imem_ack = 1'b0; bus.id_ready = 1'b1;
      step();
      pc_source = 2'd2; register_pc = 32'hFFFF_FFFF;
      step();                                  // DROP
      pc_source = 2'd0; bus.imem_ack = 1'b1;
      step();
      vectors++;
      if (bus.imem_addr !== 32'hFFFF_FFFC || bus.if_valid !== 1'b0) begin
         errors++; $display("FAIL wrap_req: addr=%h valid=%0b exp fffffffc/0", bus.imem_addr, bus.if_valid);
      end
      step();
      vectors++;
      if (bus.if_pc !== 32'hFFFF_FFFC || bus.if_pc_plus_4 !== 32'h0 || bus.imem_addr !== 32'h0) begin
         errors++; $display("FAIL wrap_edge: pc=%h p4=%h addr=%h exp fffffffc/0/0",
                            bus.if_pc, bus.if_pc_plus_4, bus.imem_addr);
      end
      step();
      vectors++;
      if (bus.if_pc !== 32'h0 || bus.if_pc_plus_4 !== 32'h4) begin
         errors++; $display("FAIL wrap_after: pc=%h p4=%h exp 0/4", bus.if_pc, bus.if_pc_plus_4);
      end
   endtask

   task automatic test_reset_midreq();
      apply_reset(); reset = 1'b0;
      bus.imem_ack = 1'b1; bus.id_ready = 1'b0;
      step(); step();
      vectors++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || bus.if_valid !== 1'b1) begin
         errors++; $display("FAIL midreq_setup: req=%0b addr=%h valid=%0b exp 1/00000004/1",
                            bus.imem_req, bus.imem_addr, bus.if_valid);
      end
      bus.imem_ack = 1'b0; reset = 1'b1;
      step();
      reset = 1'b0;
      vectors++;
      if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h0 || bus.if_pc !== 32'h0) begin
         errors++; $display("FAIL midreq_reset: req=%0b valid=%0b addr=%h pc=%h exp 0/0/0/0",
                            bus.imem_req, bus.if_valid, bus.imem_addr, bus.if_pc);
      end
      step();
      vectors++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
         errors++; $display("FAIL midreq_restart: req=%0b addr=%h exp 1/0", bus.imem_req, bus.imem_addr);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_jump_drop();
      test_branch_on_ack();
      test_double_redirect();
      test_wrap();
      test_reset_midreq();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
